// File: rtl/mvm_row_sequencer_if.sv
// Job control, fetch strobe and result-stream bundle of the MVM row sequencer.
// The slave modport is the sequencer's view; master is the surrounding datapath.
interface mvm_row_sequencer_if #(
  parameter int N      = 8,
  parameter int ROW_W  = 8,
  parameter int TILE_W = 4
);
  logic              start;
  logic [ROW_W-1:0]  num_rows;
  logic [TILE_W-1:0] num_tiles;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ROW_W-1:0]  mem_row;
  logic [TILE_W-1:0] mem_tile;
  logic [N-1:0]      mvm_v;
  logic              res_valid;
  logic              res_ready;
  logic [N-1:0]      res_data;
  logic [ROW_W-1:0]  res_row;

  modport slave (
    input  start, num_rows, num_tiles, mvm_v, res_ready,
    output busy, done, mem_rd_en, mem_row, mem_tile, res_valid, res_data, res_row
  );

  modport master (
    output start, num_rows, num_tiles, mvm_v, res_ready,
    input  busy, done, mem_rd_en, mem_row, mem_tile, res_valid, res_data, res_row
  );
endinterface

// File: rtl/mvm_row_sequencer.sv
// Row-by-row MVM job sequencer: issues tile fetches, accumulates results, streams row sums.
// MVM_SEQ_TILE_ACC_EN enables multi-tile saturating accumulation; otherwise one tile per row.
module mvm_row_sequencer #(
  parameter int N      = 8,
  parameter int ROW_W  = 8,
  parameter int TILE_W = 4,
  parameter int LAT    = 2
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  mvm_row_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, FIN} state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d, r_q, r_d, res_row_q, res_row_d;
  logic [TILE_W-1:0] t_q, t_d, tile_q, tile_d, t_in;
  logic [N-1:0]      acc_q, acc_d, res_data_q, res_data_d, acc_add;
  logic [LAT-1:0]    vld_q, vld_d;
  logic              zero_q, zero_d;
  logic              rd_en;

  // In-flight tracker: bit LAT-1 marks the cycle the matching mvm_v is valid.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_vld
    if (gi == 0) begin : g_head
      assign vld_d[gi] = rd_en;
    end else begin : g_tail
      assign vld_d[gi] = vld_q[gi-1];
    end
  end

`ifdef MVM_SEQ_TILE_ACC_EN
  logic [N:0] acc_sum;
  assign acc_sum      = {1'b0, acc_q} + {1'b0, bus.mvm_v};
  assign acc_add      = acc_sum[N] ? {N{1'b1}} : acc_sum[N-1:0];
  assign t_in         = (bus.num_tiles == '0) ? TILE_W'(1) : bus.num_tiles;
  assign bus.mem_tile = rd_en ? tile_q : '0;
`else
  logic unused_tiles;
  assign unused_tiles = ^bus.num_tiles;
  assign acc_add      = bus.mvm_v;
  assign t_in         = TILE_W'(1);
  assign bus.mem_tile = '0;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    r_d        = r_q;
    t_d        = t_q;
    tile_d     = tile_q;
    zero_d     = zero_q;
    res_data_d = res_data_q;
    res_row_d  = res_row_q;
    rd_en      = 1'b0;
    acc_d      = vld_q[LAT-1] ? acc_add : acc_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          r_d    = bus.num_rows;
          t_d    = t_in;
          row_d  = '0;
          tile_d = '0;
          if (bus.num_rows == '0) begin
            // An empty job still spends one busy cycle before its done pulse.
            state_d = FIN;
            zero_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            acc_d   = '0;
          end
        end
      end
      ISSUE: begin
        rd_en = 1'b1;
        if (tile_q == t_q - TILE_W'(1)) begin
          tile_d  = '0;
          state_d = DRAIN;
        end else begin
          tile_d = tile_q + TILE_W'(1);
        end
      end
      DRAIN: begin
        if (vld_q == '0) begin
          state_d    = OUT;
          res_data_d = acc_q;
          res_row_d  = row_q;
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          if (row_q == r_q - ROW_W'(1)) begin
            state_d = FIN;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = ISSUE;
            acc_d   = '0;
          end
        end
      end
      FIN: begin
        if (zero_q) zero_d = 1'b0;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      r_q        <= '0;
      t_q        <= '0;
      tile_q     <= '0;
      acc_q      <= '0;
      res_data_q <= '0;
      res_row_q  <= '0;
      vld_q      <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      r_q        <= r_d;
      t_q        <= t_d;
      tile_q     <= tile_d;
      acc_q      <= acc_d;
      res_data_q <= res_data_d;
      res_row_q  <= res_row_d;
      vld_q      <= vld_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_row   = rd_en ? row_q : '0;
  assign bus.busy      = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == OUT) ||
                         ((state_q == FIN) && zero_q);
  assign bus.done      = (state_q == FIN) && !zero_q;
  assign bus.res_valid = (state_q == OUT);
  assign bus.res_data  = res_data_q;
  assign bus.res_row   = res_row_q;
endmodule
